// File: rtl/cart_loader.sv
// cart_loader: turns the HPS ioctl download stream into paced 16-bit writes
// to the cartridge ROM dual-port RAM, one write per ce window, while snooping
// the cartridge header bytes the mappers need.
module cart_loader #(
  parameter int         ADDR_W  = 16,
  parameter logic [7:0] IDX_GB  = 8'h01,
  parameter logic [7:0] IDX_GBC = 8'h41,
  parameter logic [7:0] IDX_ALT = 8'h80
) (
  input  logic              clk_sys,
  input  logic              reset,
  input  logic              ce,
  input  logic              ioctl_download,
  input  logic [7:0]        ioctl_index,
  input  logic              ioctl_wr,
  input  logic [24:0]       ioctl_addr,
  input  logic [15:0]       ioctl_dout,
  output logic              ioctl_wait,
  output logic              cart_download,
  output logic              rom_we,
  output logic [ADDR_W-1:0] rom_addr,
  output logic [15:0]       rom_din,
  output logic [7:0]        cart_cgb_flag,
  output logic [7:0]        cart_mbc_type,
  output logic [7:0]        cart_rom_size,
  output logic [7:0]        cart_ram_size,
  output logic              cart_ready,
  output logic              overflow
);

  typedef enum logic [1:0] {IDLE, ARM, WRITE} state_t;

  state_t state;
  state_t state_next;

  logic latch_word;
  logic issue_write;
  logic finish_write;
  logic addr_out_of_range;
  logic pend_out_of_range;
  logic cart_download_prev;
  logic download_start;
  logic unused_addr_lsb;

  // Byte addresses are always even, so bit 0 carries no information.
  assign unused_addr_lsb = ioctl_addr[0];

  assign cart_download = ioctl_download &&
                         ((ioctl_index == IDX_GB) ||
                          (ioctl_index == IDX_GBC) ||
                          (ioctl_index == IDX_ALT));

  // Any set bit above the ROM word-address field means the word cannot be stored.
  assign addr_out_of_range = |ioctl_addr[24:ADDR_W+1];

  assign download_start = cart_download && !cart_download_prev;

  // Handshake state register.
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next state plus one-cycle strobes that steer the datapath registers.
  always_comb begin
    state_next   = state;
    latch_word   = 1'b0;
    issue_write  = 1'b0;
    finish_write = 1'b0;
    case (state)
      IDLE: begin
        if (ioctl_wr && cart_download) begin
          latch_word = 1'b1;
          state_next = ARM;
        end
      end
      ARM: begin
        if (ce) begin
          issue_write = 1'b1;
          state_next  = WRITE;
        end
      end
      WRITE: begin
        if (ce) begin
          finish_write = 1'b1;
          state_next   = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Registered outputs: word latch, write pacing, status flags and header snoop.
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      ioctl_wait         <= 1'b0;
      rom_we             <= 1'b0;
      rom_addr           <= '0;
      rom_din            <= '0;
      cart_cgb_flag      <= '0;
      cart_mbc_type      <= '0;
      cart_rom_size      <= '0;
      cart_ram_size      <= '0;
      cart_ready         <= 1'b0;
      overflow           <= 1'b0;
      pend_out_of_range  <= 1'b0;
      cart_download_prev <= 1'b0;
    end else begin
      cart_download_prev <= cart_download;
      if (download_start) begin
        cart_ready <= 1'b0;
        overflow   <= 1'b0;
      end
      if (latch_word) begin
        ioctl_wait        <= 1'b1;
        rom_addr          <= ioctl_addr[ADDR_W:1];
        rom_din           <= ioctl_dout;
        pend_out_of_range <= addr_out_of_range;
        if (ioctl_addr == 25'h142) begin
          cart_cgb_flag <= ioctl_dout[15:8];
        end
        if (ioctl_addr == 25'h146) begin
          cart_mbc_type <= ioctl_dout[15:8];
        end
        if (ioctl_addr == 25'h148) begin
          cart_rom_size <= ioctl_dout[7:0];
          cart_ram_size <= ioctl_dout[15:8];
        end
      end
      if (issue_write) begin
        if (pend_out_of_range) begin
          overflow <= 1'b1;
        end else begin
          rom_we <= 1'b1;
        end
      end
      if (finish_write) begin
        rom_we     <= 1'b0;
        ioctl_wait <= 1'b0;
        if (rom_we) begin
          cart_ready <= 1'b1;
        end
      end
    end
  end

endmodule
